// File: rtl/spi_slave_word_xcvr.sv
// SPI mode-0 slave: oversamples SCLK/MOSI/CS_n on the system clock, gathers up to
// MAX_BYTES_PER_CS bytes per CS frame into a word and shifts out a preloaded reply.
module spi_slave_word_xcvr #(
   parameter int MAX_BYTES_PER_CS = 4,
   parameter int SYNC_STAGES      = 2
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_SPI_Clk,
   input  logic        i_SPI_MOSI,
   input  logic        i_SPI_CS_n,
   output logic        o_SPI_MISO,
   output logic        o_SPI_MISO_En,
   input  logic [31:0] i_TX_Word,
   input  logic        i_TX_DV,
   output logic        o_TX_Ready,
   output logic [7:0]  o_RX_Byte,
   output logic        o_RX_DV,
   output logic [31:0] o_RX_Word,
   output logic [2:0]  o_RX_Count,
   output logic        o_RX_Word_DV,
   output logic        o_Frame_Err
);

   typedef enum logic [1:0] {S_WAIT_IDLE, S_IDLE, S_ACTIVE, S_END} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   cs_prev_q, cs_prev_d;
   logic [31:0]            tx_shadow_q, tx_shadow_d;
   logic                   tx_valid_q, tx_valid_d;
   logic [5:0]             tx_pos_q, tx_pos_d;
   logic [6:0]             rx_sr_q, rx_sr_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [2:0]             byte_cnt_q, byte_cnt_d;
   logic                   overflow_q, overflow_d;
   logic [31:0]            lanes_q, lanes_d;
   logic                   miso_q, miso_d;
   logic                   miso_en_q, miso_en_d;
   logic [7:0]             rx_byte_q, rx_byte_d;
   logic                   rx_dv_q, rx_dv_d;
   logic [31:0]            rx_word_q, rx_word_d;
   logic [2:0]             rx_count_q, rx_count_d;
   logic                   word_dv_q, word_dv_d;
   logic                   frame_err_q, frame_err_d;

   logic sclk_s, mosi_s, cs_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [7:0] byte_new;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;
   assign byte_new  = {rx_sr_q, mosi_s};

   always_comb begin
      state_d     = state_q;
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_SPI_Clk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS_n};
      sclk_prev_d = sclk_s;
      cs_prev_d   = cs_s;
      tx_shadow_d = tx_shadow_q;
      tx_valid_d  = tx_valid_q;
      tx_pos_d    = tx_pos_q;
      rx_sr_d     = rx_sr_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      overflow_d  = overflow_q;
      lanes_d     = lanes_q;
      miso_d      = 1'b0;
      rx_byte_d   = rx_byte_q;
      rx_dv_d     = 1'b0;
      rx_word_d   = rx_word_q;
      rx_count_d  = rx_count_q;
      word_dv_d   = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         S_WAIT_IDLE: begin
            if (cs_s) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (i_TX_DV) begin
               tx_shadow_d = i_TX_Word;
               tx_valid_d  = 1'b1;
            end
            if (cs_fall) begin
               state_d    = S_ACTIVE;
               tx_pos_d   = 6'd0;
               rx_sr_d    = 7'd0;
               bit_cnt_d  = 3'd0;
               byte_cnt_d = 3'd0;
               overflow_d = 1'b0;
               lanes_d    = 32'd0;
               // uses the _d values so a load coinciding with CS fall is sent
               miso_d     = tx_valid_d & tx_shadow_d[7];
            end
         end
         S_ACTIVE: begin
            miso_d = miso_q;
            if (cs_rise) begin
               // CS rise wins over any SCLK edge in the same cycle
               state_d     = S_END;
               rx_word_d   = lanes_q;
               rx_count_d  = byte_cnt_q;
               word_dv_d   = 1'b1;
               frame_err_d = (bit_cnt_q != 3'd0) | overflow_q;
               tx_valid_d  = 1'b0;
               miso_d      = 1'b0;
            end else begin
               if (sclk_rise) begin
                  rx_sr_d   = byte_new[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rx_byte_d = byte_new;
                     rx_dv_d   = 1'b1;
                     for (int i = 0; i < MAX_BYTES_PER_CS; i++) begin
                        if (byte_cnt_q == 3'(i)) lanes_d[8*i +: 8] = byte_new;
                     end
                     if (byte_cnt_q >= 3'(MAX_BYTES_PER_CS)) overflow_d = 1'b1;
                     if (byte_cnt_q != 3'd4) byte_cnt_d = byte_cnt_q + 3'd1;
                  end
               end
               if (sclk_fall) begin
                  // tx_pos counts bits already shifted; 32 means reply exhausted
                  tx_pos_d = (tx_pos_q == 6'd32) ? 6'd32 : tx_pos_q + 6'd1;
                  miso_d   = tx_valid_q && (tx_pos_d != 6'd32) &&
                             tx_shadow_q[{tx_pos_d[4:3], ~tx_pos_d[2:0]}];
               end
            end
         end
         S_END: begin
            state_d = S_IDLE;
         end
         default: state_d = S_WAIT_IDLE;
      endcase

      miso_en_d = (state_d == S_ACTIVE);
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q     <= S_WAIT_IDLE;
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b0;
         tx_shadow_q <= 32'd0;
         tx_valid_q  <= 1'b0;
         tx_pos_q    <= 6'd0;
         rx_sr_q     <= 7'd0;
         bit_cnt_q   <= 3'd0;
         byte_cnt_q  <= 3'd0;
         overflow_q  <= 1'b0;
         lanes_q     <= 32'd0;
         miso_q      <= 1'b0;
         miso_en_q   <= 1'b0;
         rx_byte_q   <= 8'd0;
         rx_dv_q     <= 1'b0;
         rx_word_q   <= 32'd0;
         rx_count_q  <= 3'd0;
         word_dv_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cs_sync_q   <= cs_sync_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
         tx_shadow_q <= tx_shadow_d;
         tx_valid_q  <= tx_valid_d;
         tx_pos_q    <= tx_pos_d;
         rx_sr_q     <= rx_sr_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         overflow_q  <= overflow_d;
         lanes_q     <= lanes_d;
         miso_q      <= miso_d;
         miso_en_q   <= miso_en_d;
         rx_byte_q   <= rx_byte_d;
         rx_dv_q     <= rx_dv_d;
         rx_word_q   <= rx_word_d;
         rx_count_q  <= rx_count_d;
         word_dv_q   <= word_dv_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign o_SPI_MISO    = miso_q;
   assign o_SPI_MISO_En = miso_en_q;
   assign o_TX_Ready    = (state_q == S_IDLE);
   assign o_RX_Byte     = rx_byte_q;
   assign o_RX_DV       = rx_dv_q;
   assign o_RX_Word     = rx_word_q;
   assign o_RX_Count    = rx_count_q;
   assign o_RX_Word_DV  = word_dv_q;
   assign o_Frame_Err   = frame_err_q;

endmodule
